// File: rtl/mips_cpu_bus_memory_ws.sv
// Byte-addressed Avalon-style RAM model with fixed or LFSR-driven wait states.
// Bus-side state resets asynchronously; memory contents survive reset.
module mips_cpu_bus_memory_ws #(
    parameter int unsigned ADDR_WIDTH    = 24,
    parameter int unsigned WAIT_CYCLES   = 0,
    parameter bit          RANDOM_WAIT   = 1'b0,
    parameter string       RAM_INIT_FILE = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [3:0]            byteenable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           writedata,
    output logic                  waitrequest,
    output logic [31:0]           readdata
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] lfsr_q;
    logic [7:0]  mem [Depth];
    logic [31:0] rd_word;
    logic [4:0]  lat_wide;
    logic [3:0]  lat;
    logic        single_req;
    logic        any_req;
    logic        capture;
    logic        commit;
    logic        unused_addr;

    assign unused_addr = ^addr[1:0];

    initial begin
        for (int i = 0; i < int'(Depth); i++) begin
            mem[i] = 8'h00;
        end
    end

    assign single_req = read ^ write;
    assign any_req    = read | write;

    always_comb begin
        lat_wide = {1'b0, lfsr_q[3:0]} % 5'(WAIT_CYCLES + 1);
        if (RANDOM_WAIT) begin
            lat = lat_wide[3:0];
        end else begin
            lat = 4'(WAIT_CYCLES);
        end
    end

    // Disabled lanes read as zero; no lane shifting.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (byteenable[i]) begin
                rd_word[8*i +: 8] = mem[{addr[ADDR_WIDTH-1:2], 2'(i)}];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture     = 1'b0;
        waitrequest = 1'b0;
        unique case (state_q)
            StIdle: begin
                waitrequest = single_req;
                if (single_req) begin
                    cnt_d = lat;
                    if (lat == 4'd0) begin
                        capture = read;
                        state_d = StAck;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                waitrequest = 1'b1;
                if (!any_req) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        capture = read & ~write;
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // A dropped or illegal request in ACK leaves memory untouched.
    assign commit = (state_q == StAck) && write && !read && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            readdata <= 32'h0;
            lfsr_q   <= 16'hACE1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lfsr_q  <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
            if (capture) begin
                readdata <= rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (byteenable[i]) begin
                    mem[{addr[ADDR_WIDTH-1:2], 2'(i)}] <= writedata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_memory_ws.sv
// Directed bench for mips_cpu_bus_memory_ws: four instances cover zero, fixed,
// random and reset-interrupted latency configurations.
module tb_mips_cpu_bus_memory_ws;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd   [4];
    logic        wr   [4];
    logic [3:0]  be   [4];
    logic [11:0] ad   [4];
    logic [31:0] wd   [4];
    logic        wreq [4];
    logic [31:0] rdat [4];

    int vectors = 0;
    int fails   = 0;
    int lat1 [200];

    always #5 clk = ~clk;

    mips_cpu_bus_memory_ws #(.ADDR_WIDTH(12), .WAIT_CYCLES(0), .RANDOM_WAIT(1'b0)) u_w0 (
        .clk(clk), .reset(reset), .read(rd[0]), .write(wr[0]), .byteenable(be[0]),
        .addr(ad[0]), .writedata(wd[0]), .waitrequest(wreq[0]), .readdata(rdat[0])
    );
    mips_cpu_bus_memory_ws #(.ADDR_WIDTH(12), .WAIT_CYCLES(3), .RANDOM_WAIT(1'b0)) u_w3 (
        .clk(clk), .reset(reset), .read(rd[1]), .write(wr[1]), .byteenable(be[1]),
        .addr(ad[1]), .writedata(wd[1]), .waitrequest(wreq[1]), .readdata(rdat[1])
    );
    mips_cpu_bus_memory_ws #(.ADDR_WIDTH(12), .WAIT_CYCLES(7), .RANDOM_WAIT(1'b1)) u_rnd (
        .clk(clk), .reset(reset), .read(rd[2]), .write(wr[2]), .byteenable(be[2]),
        .addr(ad[2]), .writedata(wd[2]), .waitrequest(wreq[2]), .readdata(rdat[2])
    );
    mips_cpu_bus_memory_ws #(.ADDR_WIDTH(12), .WAIT_CYCLES(4), .RANDOM_WAIT(1'b0)) u_w4 (
        .clk(clk), .reset(reset), .read(rd[3]), .write(wr[3]), .byteenable(be[3]),
        .addr(ad[3]), .writedata(wd[3]), .waitrequest(wreq[3]), .readdata(rdat[3])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        return 32'h1357_0000 + 32'(i) * 32'h0000_1111;
    endfunction

    // Entered and left 1 time unit after a rising edge; post samples waitrequest
    // just after the edge leaving ACK while the request is still held.
    task automatic xfer(input int d, input logic is_wr, input logic [11:0] a,
                        input logic [31:0] data, input logic [3:0] mask,
                        output logic [31:0] rdata_o, output int hi, output logic post);
        bit done = 1'b0;
        rd[d] = ~is_wr;
        wr[d] = is_wr;
        ad[d] = a;
        wd[d] = data;
        be[d] = mask;
        hi = 0;
        rdata_o = '0;
        for (int k = 0; k < 40 && !done; k++) begin
            #1;
            if (wreq[d]) begin
                hi++;
                @(posedge clk);
                #1;
            end else begin
                done = 1'b1;
                rdata_o = rdat[d];
            end
        end
        if (!done) begin
            vectors++;
            fails++;
            $error("FAIL timeout dut%0d: observed waitrequest stuck, expected release", d);
        end
        @(posedge clk);
        #1;
        post = wreq[d];
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    task automatic wr_chk(input int d, input logic [11:0] a, input logic [31:0] data,
                          input logic [3:0] mask, input int exp_hi, input string tag);
        logic [31:0] r;
        int h;
        logic p;
        xfer(d, 1'b1, a, data, mask, r, h, p);
        check({tag, " wait"}, 32'(h), 32'(exp_hi));
        check({tag, " ack1"}, 32'(p), 32'd1);
    endtask

    task automatic rd_chk(input int d, input logic [11:0] a, input logic [3:0] mask,
                          input logic [31:0] exp_data, input int exp_hi, input string tag);
        logic [31:0] r;
        int h;
        logic p;
        xfer(d, 1'b0, a, 32'h0, mask, r, h, p);
        check({tag, " data"}, r, exp_data);
        check({tag, " wait"}, 32'(h), 32'(exp_hi));
        check({tag, " ack1"}, 32'(p), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        int h;
        logic p;
        int nd;
        for (int d = 0; d < 4; d++) begin
            rd[d] = 1'b0;
            wr[d] = 1'b0;
            be[d] = 4'h0;
            ad[d] = '0;
            wd[d] = '0;
        end
        @(posedge clk);
        #1;
        do_reset();
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset rdata%0d", d), rdat[d], 32'h0);
            check($sformatf("reset wreq%0d", d), 32'(wreq[d]), 32'd0);
        end

        // Zero wait states
        wr_chk(0, 12'h100, 32'hDEADBEEF, 4'hF, 1, "w0 write");
        rd_chk(0, 12'h100, 4'hF, 32'hDEADBEEF, 1, "w0 read");

        // Partial lanes
        wr_chk(0, 12'h200, 32'h11223344, 4'hF, 1, "lanes base");
        wr_chk(0, 12'h200, 32'hAABBCCDD, 4'b0101, 1, "lanes 0101");
        rd_chk(0, 12'h200, 4'hF, 32'h11BB33DD, 1, "lanes full");
        rd_chk(0, 12'h200, 4'b0010, 32'h0000_3300, 1, "lanes 0010");

        // Misaligned, empty mask
        rd_chk(0, 12'h103, 4'hF, 32'hDEADBEEF, 1, "misaligned");
        wr_chk(0, 12'h100, 32'h0, 4'h0, 1, "be0 write");
        rd_chk(0, 12'h100, 4'hF, 32'hDEADBEEF, 1, "be0 unchanged");
        rd_chk(0, 12'h100, 4'h0, 32'h0, 1, "be0 read");

        // Illegal read+write
        rd[0] = 1'b1;
        wr[0] = 1'b1;
        ad[0] = 12'h100;
        wd[0] = 32'h0;
        be[0] = 4'hF;
        #1;
        check("illegal wreq", 32'(wreq[0]), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("illegal wreq hold", 32'(wreq[0]), 32'd0);
        rd[0] = 1'b0;
        wr[0] = 1'b0;
        rd_chk(0, 12'h100, 4'hF, 32'hDEADBEEF, 1, "illegal unchanged");

        // Fixed three wait states
        wr_chk(1, 12'h040, 32'h12345678, 4'hF, 4, "w3 write");
        rd_chk(1, 12'h040, 4'hF, 32'h12345678, 4, "w3 read");

        // Reset in the third WAIT cycle of a write
        wr_chk(3, 12'h080, 32'hCAFEF00D, 4'hF, 5, "w4 pre");
        rd_chk(3, 12'h080, 4'hF, 32'hCAFEF00D, 5, "w4 read");
        rd[3] = 1'b0;
        wr[3] = 1'b1;
        ad[3] = 12'h080;
        wd[3] = 32'h55555555;
        be[3] = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("w4 in wait", 32'(wreq[3]), 32'd1);
        reset = 1'b1;
        #1;
        check("rst rdata", rdat[3], 32'h0);
        check("rst wreq held", 32'(wreq[3]), 32'd1);
        wr[3] = 1'b0;
        #1;
        check("rst wreq idle", 32'(wreq[3]), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        rd_chk(3, 12'h080, 4'hF, 32'hCAFEF00D, 5, "rst unchanged");

        // Random latency
        do_reset();
        for (int i = 0; i < 16; i++) begin
            xfer(2, 1'b1, 12'(i * 4), exp_word(i), 4'hF, r, h, p);
        end
        do_reset();
        for (int j = 0; j < 200; j++) begin
            xfer(2, 1'b0, 12'((j % 16) * 4), 32'h0, 4'hF, r, h, p);
            lat1[j] = h;
            check($sformatf("rnd data %0d", j), r, exp_word(j % 16));
            check($sformatf("rnd range %0d", j), 32'(h >= 1 && h <= 8), 32'd1);
        end
        // Seed ACE1 gives L=1, then after three shifts 559C gives L=4
        check("rnd lat0", 32'(lat1[0]), 32'd2);
        check("rnd lat1", 32'(lat1[1]), 32'd5);
        nd = 0;
        for (int j = 0; j < 200; j++) begin
            if (lat1[j] != lat1[0]) nd++;
        end
        check("rnd varies", 32'(nd > 0), 32'd1);
        do_reset();
        for (int j = 0; j < 200; j++) begin
            xfer(2, 1'b0, 12'((j % 16) * 4), 32'h0, 4'hF, r, h, p);
            check($sformatf("rnd repeat %0d", j), 32'(h), 32'(lat1[j]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
